fir_mult_sequencer: RTL

- Control FSM for the 33-tap systolic FIR datapath built from sequential multipliers on clk30x.
- Accepts one input sample per valid/ready handshake and latches it as the common multiplier operand.
- Issues a one-cycle start to all multiplier instances, waits until every busy flag has cleared, then strobes the accumulate-enable that advances the systolic adder chain and output register.
- Replaces the fixed free-running count-to-29 sequencing with a busy-driven handshake, and adds a watchdog for multipliers that hang.

---
 rtl/fir_mult_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/fir_mult_sequencer.sv
// Sequencing FSM for the systolic FIR: latches a sample, starts all multipliers,
// waits for every busy flag to drop (with a watchdog), then strobes the adder chain.
module fir_mult_sequencer #(
    parameter int unsigned DW      = 16,
    parameter int unsigned N_TAPS  = 33,
    parameter int unsigned TIMEOUT = 31,
    parameter int unsigned CW      = 6
) (
    input  logic              clk30x,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     xin,
    output logic [DW-1:0]     x_op,
    output logic              mult_start,
    input  logic [N_TAPS-1:0] mult_busy,
    output logic              acc_en,
    output logic              out_valid,
    output logic              timeout_err,
    input  logic              clr_err,
    output logic [15:0]       sample_cnt,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [2:0] {StIdle, StStart, StArm, StWait, StAcc, StAbort} state_e;

    state_e        r_state;
    logic [CW-1:0] r_wdog;
    logic          r_in_ready;
    logic [DW-1:0] r_x_op;
    logic          r_mult_start;
    logic          r_acc_en;
    logic          r_out_valid;
    logic          r_timeout_err;
    logic [15:0]   r_sample_cnt;
    logic [7:0]    r_drop_cnt;

    logic w_accept;
    logic w_busy;
    logic w_wdog_hit;

    assign w_accept   = in_valid & r_in_ready;
    assign w_busy     = |mult_busy;
    assign w_wdog_hit = (r_wdog == CW'(TIMEOUT));

    always_ff @(posedge clk30x) begin
        if (rst) begin
            r_state       <= StIdle;
            r_wdog        <= '0;
            r_in_ready    <= 1'b0;
            r_x_op        <= '0;
            r_mult_start  <= 1'b0;
            r_acc_en      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_sample_cnt  <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_mult_start <= 1'b0;
            r_acc_en     <= 1'b0;
            r_out_valid  <= (r_state == StAcc);
            r_in_ready   <= 1'b0;
            // A later set in StAbort overrides this clear
            if (clr_err) r_timeout_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_x_op       <= xin;
                        r_mult_start <= 1'b1;
                        r_state      <= StStart;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                StStart: r_state <= StArm;
                StArm: begin
                    r_wdog  <= CW'(1);
                    r_state <= StWait;
                end
                StWait: begin
                    if (!w_busy) begin
                        r_acc_en <= 1'b1;
                        r_state  <= StAcc;
                    end else if (w_wdog_hit) begin
                        r_state <= StAbort;
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                StAcc: begin
                    r_sample_cnt <= r_sample_cnt + 16'd1;
                    r_in_ready   <= 1'b1;
                    r_state      <= StIdle;
                end
                StAbort: begin
                    r_timeout_err <= 1'b1;
                    if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
                    r_in_ready <= 1'b1;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign x_op        = r_x_op;
    assign mult_start  = r_mult_start;
    assign acc_en      = r_acc_en;
    assign out_valid   = r_out_valid;
    assign timeout_err = r_timeout_err;
    assign sample_cnt  = r_sample_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule
